// File: rtl/fwd_hazard_ctrl.sv
// Operand-forwarding select and load-use stall controller for the EX stage.
// Tracks EX/MEM/WB destination records and registers the select codes for the EX operand muxes.
module fwd_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  enable,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    output logic [1:0]            fwd_sel_a,
    output logic [1:0]            fwd_sel_b,
    output logic                  stall,
    output logic [CNT_W-1:0]      stall_count
);

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_WB  = 2'd2;

    logic                  ex_valid_q,  ex_valid_d;
    logic [REG_ADDR_W-1:0] ex_rs1_q,    ex_rs1_d;
    logic [REG_ADDR_W-1:0] ex_rs2_q,    ex_rs2_d;
    logic [REG_ADDR_W-1:0] ex_rd_q,     ex_rd_d;
    logic                  ex_rw_q,     ex_rw_d;
    logic                  ex_mr_q,     ex_mr_d;

    logic                  mem_valid_q;
    logic [REG_ADDR_W-1:0] mem_rd_q;
    logic                  mem_rw_q;

    logic                  wb_valid_q;
    logic [REG_ADDR_W-1:0] wb_rd_q;
    logic                  wb_rw_q;

    logic [1:0]            sel_a_q, sel_a_d;
    logic [1:0]            sel_b_q, sel_b_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;

    logic ex_wr_rs1, ex_wr_rs2, mem_wr_rs1, mem_wr_rs2;
    logic ex_is_load_dst;

    // A record "writes x" only for a real, writing instruction with a non-x0 destination.
    assign ex_wr_rs1  = ex_valid_q  && ex_rw_q  && (ex_rd_q  != '0) && (ex_rd_q  == id_rs1);
    assign ex_wr_rs2  = ex_valid_q  && ex_rw_q  && (ex_rd_q  != '0) && (ex_rd_q  == id_rs2);
    assign mem_wr_rs1 = mem_valid_q && mem_rw_q && (mem_rd_q != '0) && (mem_rd_q == id_rs1);
    assign mem_wr_rs2 = mem_valid_q && mem_rw_q && (mem_rd_q != '0) && (mem_rd_q == id_rs2);

    assign ex_is_load_dst = ex_valid_q && ex_mr_q && ex_rw_q && (ex_rd_q != '0);

    assign stall = id_valid && !flush && ex_is_load_dst &&
                   ((ex_rd_q == id_rs1) || (ex_rd_q == id_rs2));

    always_comb begin
        ex_valid_d = 1'b0;
        ex_rs1_d   = '0;
        ex_rs2_d   = '0;
        ex_rd_d    = '0;
        ex_rw_d    = 1'b0;
        ex_mr_d    = 1'b0;
        sel_a_d    = SEL_RF;
        sel_b_d    = SEL_RF;
        cnt_d      = cnt_q;

        if (flush) begin
            // bubble; flush outranks the stall so the counter is untouched
        end else if (stall) begin
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            ex_valid_d = id_valid;
            ex_rs1_d   = id_rs1;
            ex_rs2_d   = id_rs2;
            ex_rd_d    = id_rd;
            ex_rw_d    = id_reg_write;
            ex_mr_d    = id_mem_read;
            if (id_valid) begin
                // EX producer is newer than MEM, so it is checked first.
                if (ex_wr_rs1) begin
                    sel_a_d = SEL_MEM;
                end else if (mem_wr_rs1) begin
                    sel_a_d = SEL_WB;
                end
                if (ex_wr_rs2) begin
                    sel_b_d = SEL_MEM;
                end else if (mem_wr_rs2) begin
                    sel_b_d = SEL_WB;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ex_valid_q  <= 1'b0;
            ex_rs1_q    <= '0;
            ex_rs2_q    <= '0;
            ex_rd_q     <= '0;
            ex_rw_q     <= 1'b0;
            ex_mr_q     <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_rd_q    <= '0;
            mem_rw_q    <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_rw_q     <= 1'b0;
            sel_a_q     <= SEL_RF;
            sel_b_q     <= SEL_RF;
            cnt_q       <= '0;
        end else if (enable) begin
            ex_valid_q  <= ex_valid_d;
            ex_rs1_q    <= ex_rs1_d;
            ex_rs2_q    <= ex_rs2_d;
            ex_rd_q     <= ex_rd_d;
            ex_rw_q     <= ex_rw_d;
            ex_mr_q     <= ex_mr_d;
            mem_valid_q <= ex_valid_q;
            mem_rd_q    <= ex_rd_q;
            mem_rw_q    <= ex_rw_q;
            wb_valid_q  <= mem_valid_q;
            wb_rd_q     <= mem_rd_q;
            wb_rw_q     <= mem_rw_q;
            sel_a_q     <= sel_a_d;
            sel_b_q     <= sel_b_d;
            cnt_q       <= cnt_d;
        end
    end

    assign fwd_sel_a   = sel_a_q;
    assign fwd_sel_b   = sel_b_q;
    assign stall_count = cnt_q;

    // Once the consumer sits in EX its producer has moved one stage on, so the
    // selects must agree with the MEM/WB records against the EX source fields.
    a_sel_a_mem : assert property (@(posedge clk) disable iff (!arst_n)
        (sel_a_q == SEL_MEM) |-> (ex_valid_q && mem_valid_q && mem_rw_q && mem_rd_q == ex_rs1_q));
    a_sel_b_mem : assert property (@(posedge clk) disable iff (!arst_n)
        (sel_b_q == SEL_MEM) |-> (ex_valid_q && mem_valid_q && mem_rw_q && mem_rd_q == ex_rs2_q));
    a_sel_a_wb : assert property (@(posedge clk) disable iff (!arst_n)
        (sel_a_q == SEL_WB) |-> (ex_valid_q && wb_valid_q && wb_rw_q && wb_rd_q == ex_rs1_q));
    a_sel_b_wb : assert property (@(posedge clk) disable iff (!arst_n)
        (sel_b_q == SEL_WB) |-> (ex_valid_q && wb_valid_q && wb_rw_q && wb_rd_q == ex_rs2_q));
    a_no_code3 : assert property (@(posedge clk) disable iff (!arst_n)
        (sel_a_q != 2'd3) && (sel_b_q != 2'd3));

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed scoreboard bench for fwd_hazard_ctrl: expected selects/count queued per ID slot, checked after the edge.
module tb_fwd_hazard_ctrl;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        enable, flush, id_valid, id_reg_write, id_mem_read;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [1:0]  fwd_sel_a, fwd_sel_b;
    logic        stall;
    logic [15:0] stall_count;

    int n_cmp = 0;
    int n_err = 0;
    logic [19:0] sb_q[$];

    fwd_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(16)) dut (
        .clk(clk), .arst_n(arst_n), .enable(enable), .flush(flush),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
        .stall(stall), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic en, input logic fl, input logic v,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic rw, input logic mr);
        enable = en; flush = fl; id_valid = v;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_reg_write = rw; id_mem_read = mr;
    endtask

    // One ID slot: check stall combinationally, queue expected EX-side results, clock, compare.
    task automatic step(input string tag, input logic en, input logic fl, input logic v,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic exp_stall,
                        input logic [1:0] ea, input logic [1:0] eb, input logic [15:0] ecnt);
        logic [19:0] e;
        @(negedge clk);
        drive(en, fl, v, rs1, rs2, rd, rw, mr);
        #1;
        chk({tag, ".stall"}, {31'd0, stall}, {31'd0, exp_stall});
        sb_q.push_back({ea, eb, ecnt});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, ".sel_a"}, {30'd0, fwd_sel_a}, {30'd0, e[19:18]});
            chk({tag, ".sel_b"}, {30'd0, fwd_sel_b}, {30'd0, e[17:16]});
            chk({tag, ".cnt"},   {16'd0, stall_count}, {16'd0, e[15:0]});
        end
    endtask

    task automatic nop(input logic [15:0] cnt);
        step("nop", 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, cnt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        arst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #3;
        chk("rst.sel_a", {30'd0, fwd_sel_a}, 32'd0);
        chk("rst.sel_b", {30'd0, fwd_sel_b}, 32'd0);
        chk("rst.cnt",   {16'd0, stall_count}, 32'd0);
        chk("rst.stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        arst_n = 1'b1;

        // EX->EX forward on operand A
        step("add_x5",   1,0,1, 5'd1, 5'd2, 5'd5, 1,0, 0, 2'd0,2'd0, 16'd0);
        step("sub_x5x7", 1,0,1, 5'd5, 5'd7, 5'd6, 1,0, 0, 2'd1,2'd0, 16'd0);
        nop(16'd0); nop(16'd0);

        // MEM->EX forward on operand B
        step("add_x5b",  1,0,1, 5'd1,  5'd2,  5'd5, 1,0, 0, 2'd0,2'd0, 16'd0);
        step("xor_x9",   1,0,1, 5'd10, 5'd11, 5'd9, 1,0, 0, 2'd0,2'd0, 16'd0);
        step("or_x7x5",  1,0,1, 5'd7,  5'd5,  5'd8, 1,0, 0, 2'd0,2'd2, 16'd0);
        nop(16'd0); nop(16'd0);

        // load-use: one stall, then WB forward on both operands
        step("lw_x5",    1,0,1, 5'd1, 5'd0, 5'd5, 1,1, 0, 2'd0,2'd0, 16'd0);
        step("lu_stall", 1,0,1, 5'd5, 5'd5, 5'd6, 1,0, 1, 2'd0,2'd0, 16'd1);
        step("lu_go",    1,0,1, 5'd5, 5'd5, 5'd6, 1,0, 0, 2'd2,2'd2, 16'd1);
        nop(16'd1); nop(16'd1);

        // x0 never forwards or stalls
        step("addi_x0",  1,0,1, 5'd1, 5'd0, 5'd0,  1,0, 0, 2'd0,2'd0, 16'd1);
        step("use_x0",   1,0,1, 5'd0, 5'd0, 5'd13, 1,0, 0, 2'd0,2'd0, 16'd1);
        step("lw_x0",    1,0,1, 5'd0, 5'd0, 5'd0,  1,1, 0, 2'd0,2'd0, 16'd1);
        step("use_x0b",  1,0,1, 5'd0, 5'd0, 5'd13, 1,0, 0, 2'd0,2'd0, 16'd1);
        nop(16'd1); nop(16'd1);

        // newest producer wins
        step("add_x5c",  1,0,1, 5'd1, 5'd2, 5'd5,  1,0, 0, 2'd0,2'd0, 16'd1);
        step("sub_x5",   1,0,1, 5'd3, 5'd4, 5'd5,  1,0, 0, 2'd0,2'd0, 16'd1);
        step("use_x5",   1,0,1, 5'd5, 5'd5, 5'd14, 1,0, 0, 2'd1,2'd1, 16'd1);
        nop(16'd1); nop(16'd1);

        // flush beats load-use
        step("lw_x7",    1,0,1, 5'd1, 5'd0, 5'd7,  1,1, 0, 2'd0,2'd0, 16'd1);
        step("flush_lu", 1,1,1, 5'd7, 5'd0, 5'd8,  1,0, 0, 2'd0,2'd0, 16'd1);
        step("use_x7",   1,0,1, 5'd7, 5'd2, 5'd11, 1,0, 0, 2'd2,2'd0, 16'd1);
        nop(16'd1); nop(16'd1);

        // enable=0 freezes nonzero selects
        step("add_x5d",  1,0,1, 5'd1, 5'd2, 5'd5,  1,0, 0, 2'd0,2'd0, 16'd1);
        step("sub_x5x3", 1,0,1, 5'd5, 5'd3, 5'd6,  1,0, 0, 2'd1,2'd0, 16'd1);
        for (int i = 0; i < 3; i++)
            step("frz_sel", 0,0,1, 5'd5, 5'd5, 5'd12, 1,0, 0, 2'd1,2'd0, 16'd1);
        step("thaw_sel", 1,0,1, 5'd5, 5'd5, 5'd12, 1,0, 0, 2'd2,2'd2, 16'd1);
        nop(16'd1); nop(16'd1);

        // enable=0 during a load-use: stall visible, count frozen
        step("lw_x9",    1,0,1, 5'd1, 5'd0, 5'd9,  1,1, 0, 2'd0,2'd0, 16'd1);
        for (int i = 0; i < 3; i++)
            step("frz_lu", 0,0,1, 5'd9, 5'd1, 5'd10, 1,0, 1, 2'd0,2'd0, 16'd1);
        step("lu2_stall", 1,0,1, 5'd9, 5'd1, 5'd10, 1,0, 1, 2'd0,2'd0, 16'd2);
        step("lu2_go",    1,0,1, 5'd9, 5'd1, 5'd10, 1,0, 0, 2'd2,2'd0, 16'd2);
        nop(16'd2); nop(16'd2);

        // asynchronous reset mid-stream
        step("add_x5e",  1,0,1, 5'd1, 5'd2, 5'd5, 1,0, 0, 2'd0,2'd0, 16'd2);
        step("lw_x6",    1,0,1, 5'd5, 5'd0, 5'd6, 1,1, 0, 2'd1,2'd0, 16'd2);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 5'd6, 5'd5, 5'd7, 1'b1, 1'b0);
        #1;
        chk("pre_rst.stall", {31'd0, stall}, 32'd1);
        arst_n = 1'b0;
        #1;
        chk("arst.sel_a", {30'd0, fwd_sel_a}, 32'd0);
        chk("arst.sel_b", {30'd0, fwd_sel_b}, 32'd0);
        chk("arst.cnt",   {16'd0, stall_count}, 32'd0);
        chk("arst.stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        arst_n = 1'b1;
        step("post_x6", 1,0,1, 5'd6, 5'd5, 5'd7,  1,0, 0, 2'd0,2'd0, 16'd0);
        step("post_x5", 1,0,1, 5'd5, 5'd6, 5'd15, 1,0, 0, 2'd0,2'd0, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Generates the 2-bit operand select codes for the two EX-stage 3-input operand muxes (ALU operand A and B) of the 5-stage pipelined core.
- Keeps its own pipelined record of destination registers for the EX, MEM and WB stages.
- Detects load-use hazards and requests a one-cycle stall with bubble insertion.
- Sits between ID and EX; its select outputs drive the operand muxes directly.

Parameters:
- REG_ADDR_W, 5, register index width.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- arst_n  in  1  asynchronous active-low reset.
- enable  in  1  pipeline advance; 0 freezes all internal state and outputs.
- flush  in  1  branch/jump flush; discards the instruction currently in ID.
- id_valid  in  1  ID holds a real instruction.
- id_rs1  in  REG_ADDR_W  source register 1 of ID instruction.
- id_rs2  in  REG_ADDR_W  source register 2 of ID instruction.
- id_rd  in  REG_ADDR_W  destination register of ID instruction.
- id_reg_write  in  1  ID instruction writes rd.
- id_mem_read  in  1  ID instruction is a load.
- fwd_sel_a  out  2  operand A select for instruction in EX: 0=regfile, 1=EX/MEM result, 2=MEM/WB writeback.
- fwd_sel_b  out  2  operand B select, same encoding.
- stall  out  1  load-use stall request to PC/IF/ID registers.
- stall_count  out  CNT_W  number of stall cycles since reset, saturating.

Behaviour:
- Reset (arst_n=0, asynchronous):
  - All stage records are invalid.
  - fwd_sel_a = 0 and fwd_sel_b = 0.
  - stall_count = 0.
  - stall evaluates to 0.
- Stage records:
  - EX record holds {valid, rs1, rs2, rd, reg_write, mem_read}.
  - MEM and WB records each hold {valid, rd, reg_write}.
  - A record "writes x" when valid=1, reg_write=1, rd==x and x!=0.
- stall (combinational from state and ID inputs):
  - stall = id_valid & ~flush & EX.valid & EX.mem_read & EX.reg_write & (EX.rd!=0) & (EX.rd==id_rs1 | EX.rd==id_rs2).
- Advance rule: on a rising edge with enable=1, EX moves to MEM and MEM moves to WB. What enters EX depends on the case:
  - flush=1: EX loads a bubble (valid=0) and the selects go to 0. Flush has priority over stall.
  - stall=1: EX loads a bubble and the selects go to 0. stall_count increments, holding at all-ones.
  - Otherwise: EX loads the ID fields, with valid=id_valid.
- Registered select computation (only when an ID instruction enters EX), for each operand using id_rs1 for A and id_rs2 for B:
  - If the current EX record writes rs, the select is 1 (that instruction will be in MEM).
  - Else if the current MEM record writes rs, the select is 2.
  - Else the select is 0.
  - The newest producer wins.
  - Code 3 is never driven.
- enable=0: every register holds, including the selects and stall_count. stall still evaluates combinationally.
- Latency:
  - Selects are valid in the same cycle the instruction occupies EX, one edge after ID.
  - stall is zero-latency.
- The WB record is kept only for visibility and debug. A WB-to-ID hazard is resolved by the write-first register file, so it never produces a nonzero select.
- Reset asserted mid-operation: all in-flight records are discarded immediately, with no forwarding afterwards.

Test Plan:
- Reset, then `add x5` followed immediately by `sub x6,x5,x7` with enable=1 → when sub is in EX: fwd_sel_a=1, fwd_sel_b=0, stall never 1.
- `add x5`, an independent op, then `or x8,x7,x5` → when or is in EX: fwd_sel_a=0, fwd_sel_b=2.
- `lw x5` followed by `add x6,x5,x5`:
  - stall=1 for exactly 1 cycle while the add is in ID, and EX gets a bubble with sels=0.
  - Next cycle stall=0, and the add in EX gets sel_a=2, sel_b=2.
  - stall_count=1.
- Writes to x0 (`addi x0` followed by a use of x0) → sels stay 0. `lw x0` followed by a use of x0 → no stall.
- Double producer: `add x5`, `sub x5`, then a use of x5 → sel=1 (newest wins). Simultaneous flush and load-use → no stall, EX gets a bubble, stall_count unchanged.
- Hold enable=0 for 3 cycles mid-sequence → sels and stall_count are frozen. Assert arst_n=0 mid-stream → all outputs 0 asynchronously, and the first post-reset dependent instruction gets sel=0.
